// File: rtl/vx_ahb_pkg.sv
// Shared AHB-Lite encodings and subordinate state type for the SRAM subordinate.
// Also holds the size/alignment legality rule used at address-phase decode.
package vx_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } sub_state_t;

  // True when the transfer size is wider than a word or the address is not size-aligned.
  function automatic logic size_illegal(input logic [2:0] size, input logic [1:0] lsb);
    return (size > HSIZE_WORD) ||
           ((size == HSIZE_WORD) && (lsb != 2'b00)) ||
           ((size == HSIZE_HALF) && lsb[0]);
  endfunction

endpackage

// File: rtl/vx_ahb_sram_sub_if.sv
// AHB-Lite bus bundle between the memory adapter (master) and the SRAM subordinate.
interface vx_ahb_sram_sub_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HTRANS, HWRITE, HSIZE, HBURST, HADDR, HWDATA, HWSTRB,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HTRANS, HWRITE, HSIZE, HBURST, HADDR, HWDATA, HWSTRB,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/vx_ahb_sram_array.sv
// Word-addressed 32-bit storage: asynchronous read, synchronous byte-masked write.
// Contents are never reset.
module vx_ahb_sram_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter              INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  output logic [31:0]                    rdata,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [31:0]                    wdata
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/vx_ahb_sram_sub.sv
// AHB-Lite subordinate backed by the SRAM array, with fixed wait states and
// the two-cycle ERROR response for out-of-window or misaligned/oversized accesses.
//
//   state | meaning
//   IDLE  | no data phase in progress, ready for an address phase
//   WAIT  | OKAY data phase stalled, counter runs down to zero
//   LAST  | final OKAY data-phase cycle: read data driven / write committed
//   ERR1  | first ERROR cycle, HREADY low
//   ERR2  | second ERROR cycle, HREADY high, next address may be taken
module vx_ahb_sram_sub
  import vx_ahb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             reset,
  vx_ahb_sram_sub_if.slave bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  sub_state_t     state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [AW-1:0]  idx;
  logic           wr;

  logic           ready;
  logic           resp;
  logic [31:0]    rdata_out;
  logic [31:0]    mem_rdata;
  logic           mem_we;

  htrans_t        trans;
  logic           accept;
  logic [31:0]    off;
  logic           in_range;
  logic           addr_err;

  assign trans    = htrans_t'(bus.HTRANS);
  assign ready    = (state != ST_WAIT) && (state != ST_ERR1);
  assign accept   = bus.HSEL && (trans inside {HTRANS_NONSEQ, HTRANS_SEQ}) && ready;

  // 33-bit compare so a window ending at the top of the address space still works.
  assign off      = bus.HADDR - BASE_ADDR;
  assign in_range = (bus.HADDR >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign addr_err = !in_range || size_illegal(bus.HSIZE, bus.HADDR[1:0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx <= off[AW+1:2];
        wr  <= bus.HWRITE;
      end
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = cnt;
    resp      = HRESP_OKAY;
    rdata_out = '0;
    mem_we    = 1'b0;
    case (state)
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_LAST;
        end else begin
          state_nxt = ST_WAIT;
          cnt_nxt   = cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        resp      = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (state == ST_ERR2) resp = HRESP_ERROR;
        // The write commits on the edge that closes LAST, unless that edge is a reset.
        if (state == ST_LAST) begin
          mem_we = wr && reset;
          if (!wr) rdata_out = mem_rdata;
        end
        if (accept) begin
          if (addr_err) begin
            state_nxt = ST_ERR1;
          end else if (WS == 4'd0) begin
            state_nxt = ST_LAST;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WS - 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  vx_ahb_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .addr  (idx),
    .rdata (mem_rdata),
    .we    (mem_we),
    .be    (bus.HWSTRB),
    .wdata (bus.HWDATA)
  );

  assign bus.HREADY = ready;
  assign bus.HRESP  = resp;
  assign bus.HRDATA = rdata_out;

  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, off[31:AW+2], off[1:0]};

endmodule

// File: tb/tb_vx_ahb_sram_sub.sv
// Bench for vx_ahb_sram_sub: three instances (0, 3 and 5 wait states, one with a
// non-zero base) share one driver; a per-cycle response queue model checks the selected one.
module tb_vx_ahb_sram_sub;
  import vx_ahb_pkg::*;

  localparam int DEPTH = 64;

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 3 : 5;
  endfunction

  function automatic logic [31:0] base_of(input int s);
    return (s == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        b_hsel;
  logic [1:0]  b_htrans;
  logic        b_hwrite;
  logic [2:0]  b_hsize;
  logic [31:0] b_haddr;
  logic [31:0] b_hwdata;
  logic [3:0]  b_hwstrb;

  logic [2:0]  rdy_v, resp_v;
  logic [31:0] rdata_v [3];
  logic        d_rdy, d_resp;
  logic [31:0] d_rdata;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vx_ahb_sram_sub_if bus ();
    assign bus.HSEL   = b_hsel && (sel == 2'(g));
    assign bus.HTRANS = b_htrans;
    assign bus.HWRITE = b_hwrite;
    assign bus.HSIZE  = b_hsize;
    assign bus.HBURST = 3'b000;
    assign bus.HADDR  = b_haddr;
    assign bus.HWDATA = b_hwdata;
    assign bus.HWSTRB = b_hwstrb;
    vx_ahb_sram_sub #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (base_of(g)),
      .WAIT_STATES (ws_of(g)),
      .INIT_FILE   ("")
    ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
    );
    assign rdy_v[g]   = bus.HREADY;
    assign resp_v[g]  = bus.HRESP;
    assign rdata_v[g] = bus.HRDATA;
  end

  assign d_rdy   = rdy_v[sel];
  assign d_resp  = resp_v[sel];
  assign d_rdata = rdata_v[sel];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One entry per expected output cycle of the selected subordinate.
  typedef struct {
    bit          rdy;
    bit          resp;
    logic [31:0] data;
    bit          chkd;
    bit          wr_close;
    bit          rd;
    int          key;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  exp_t        eq[$];
  beat_t       bq[$];
  logic [31:0] mm[int];
  logic [31:0] got[$];
  int          lowcnt, errcnt, cyc;
  bit          chk_on = 1'b0;

  function automatic bit m_rdy();
    return (eq.size() == 0) ? 1'b1 : eq[0].rdy;
  endfunction

  function automatic void push_beat(input bit wr, input logic [31:0] addr, input logic [2:0] size);
    exp_t        e;
    logic [32:0] lim;
    bit          err;
    lim = {1'b0, base_of(int'(sel))} + 33'(DEPTH * 4);
    err = (addr < base_of(int'(sel))) || ({1'b0, addr} >= lim) || (size > 3'd2) ||
          ((addr % (32'd1 << size)) != 32'd0);
    e = '{default: 0};
    e.chkd = 1'b1;
    if (err) begin
      e.resp = 1'b1;
      eq.push_back(e);
      e.rdy = 1'b1;
      eq.push_back(e);
      return;
    end
    repeat (ws_of(int'(sel))) eq.push_back(e);
    e.rdy = 1'b1;
    e.key = int'(sel) * 65536 + int'((addr - base_of(int'(sel))) / 4);
    if (wr) begin
      e.wr_close = 1'b1;
    end else begin
      e.rd   = 1'b1;
      e.chkd = mm.exists(e.key);
      e.data = mm.exists(e.key) ? mm[e.key] : 32'h0;
    end
    eq.push_back(e);
  endfunction

  // Model: retire the current cycle's expectation at each edge, apply writes, queue new beats.
  always @(posedge clk) begin
    exp_t        f;
    bit          acc;
    logic [31:0] w;
    if (!rst_n) begin
      eq.delete();
    end else begin
      acc = m_rdy() && b_hsel && b_htrans[1];
      if (eq.size() > 0) begin
        f = eq.pop_front();
        if (f.wr_close) begin
          w = mm.exists(f.key) ? mm[f.key] : 32'h0;
          for (int b = 0; b < 4; b++) if (b_hwstrb[b]) w[8*b +: 8] = b_hwdata[8*b +: 8];
          if (mm.exists(f.key) || (b_hwstrb == 4'hF)) mm[f.key] = w;
        end
      end
      if (acc) push_beat(b_hwrite, b_haddr, b_hsize);
    end
  end

  always @(negedge clk) begin
    exp_t f;
    if (chk_on) begin
      if (eq.size() > 0) begin
        f = eq[0];
      end else begin
        f = '{default: 0};
        f.rdy  = 1'b1;
        f.chkd = 1'b1;
      end
      check("hready", 32'(d_rdy), 32'(f.rdy));
      check("hresp", 32'(d_resp), 32'(f.resp));
      if (f.chkd) check("hrdata", d_rdata, f.data);
      if (f.rd && f.rdy) got.push_back(d_rdata);
      if (!d_rdy) lowcnt++;
      if (d_resp) errcnt++;
    end
  end

  task automatic add(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] data, input logic [3:0] strb);
    beat_t b;
    b.wr = wr; b.addr = addr; b.size = size; b.data = data; b.strb = strb;
    bq.push_back(b);
  endtask

  task automatic clear_stats();
    got.delete();
    lowcnt = 0;
    errcnt = 0;
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got.size() > i) ? got[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic bus_idle();
    b_hsel = 1'b0; b_htrans = 2'b00; b_hwrite = 1'b0; b_hsize = 3'd2;
    b_haddr = '0; b_hwdata = '0; b_hwstrb = '0;
  endtask

  // Pipelined master: address of the next beat overlaps the data phase of the current one.
  task automatic run_beats();
    beat_t d;
    bit    have_d = 1'b0;
    bit    first  = 1'b1;
    bit    rdy;
    int    n = 0;
    while (bq.size() > 0 || have_d) begin
      if (bq.size() > 0) begin
        b_hsel = 1'b1; b_htrans = first ? 2'b10 : 2'b11;
        b_hwrite = bq[0].wr; b_haddr = bq[0].addr; b_hsize = bq[0].size;
      end else begin
        b_hsel = 1'b0; b_htrans = 2'b00;
      end
      b_hwdata = have_d ? d.data : 32'h0;
      b_hwstrb = have_d ? d.strb : 4'h0;
      @(negedge clk);
      rdy = m_rdy();
      @(posedge clk);
      #1;
      n++;
      if (rdy) begin
        first  = 1'b0;
        have_d = (bq.size() > 0);
        if (have_d) d = bq.pop_front();
      end
      if (n > 500) begin
        check("run_timeout", 32'(n), 32'd500);
        bq.delete();
        have_d = 1'b0;
      end
    end
    bus_idle();
    cyc = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sel   = 2'd0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_hready", 32'(rdy_v[s]), 32'd1);
      check("rst_hresp", 32'(resp_v[s]), 32'd0);
      check("rst_hrdata", rdata_v[s], 32'd0);
    end
    @(posedge clk); #1;
    chk_on = 1'b1;

    // Zero-wait write then read, one beat per cycle.
    sel = 2'd0;
    clear_stats();
    add(1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 4'hF);
    add(0, 32'h10, HSIZE_WORD, 32'h0, 4'h0);
    run_beats();
    check("t1_rdata", got_at(0), 32'hDEADBEEF);
    check("t1_cycles", 32'(cyc), 32'd3);
    check("t1_low", 32'(lowcnt), 32'd0);

    // 16 back-to-back writes followed by 16 back-to-back reads.
    clear_stats();
    for (int i = 0; i < 16; i++) add(1, 32'h40 + 32'(4 * i), HSIZE_WORD, 32'(i), 4'hF);
    for (int i = 0; i < 16; i++) add(0, 32'h40 + 32'(4 * i), HSIZE_WORD, 32'h0, 4'h0);
    run_beats();
    check("t2_cycles", 32'(cyc), 32'd33);
    check("t2_low", 32'(lowcnt), 32'd0);
    for (int i = 0; i < 16; i++) check("t2_burst_rd", got_at(i), 32'(i));

    // Byte strobes, with read-after-write on consecutive beats.
    clear_stats();
    add(1, 32'h8, HSIZE_WORD, 32'hFFFFFFFF, 4'hF);
    add(1, 32'h8, HSIZE_WORD, 32'h00000000, 4'b0101);
    add(0, 32'h8, HSIZE_WORD, 32'h0, 4'h0);
    run_beats();
    check("t3_strb", got_at(0), 32'hFF00FF00);

    // Illegal accesses: past the window, misaligned word, oversized, misaligned half.
    clear_stats();
    add(1, 32'h0, HSIZE_WORD, 32'hA5A5A5A5, 4'hF);
    add(0, 32'h100, HSIZE_WORD, 32'h0, 4'h0);
    add(1, 32'h2, HSIZE_WORD, 32'h55555555, 4'hF);
    add(0, 32'h0, 3'b011, 32'h0, 4'h0);
    add(1, 32'h1, HSIZE_HALF, 32'h66666666, 4'hF);
    add(0, 32'h0, HSIZE_WORD, 32'h0, 4'h0);
    run_beats();
    check("t4_errcyc", 32'(errcnt), 32'd8);
    check("t4_low", 32'(lowcnt), 32'd4);
    check("t4_unchanged", got_at(0), 32'hA5A5A5A5);

    // Three wait states on a single read.
    sel = 2'd1;
    add(1, 32'h20, HSIZE_WORD, 32'h13572468, 4'hF);
    run_beats();
    clear_stats();
    add(0, 32'h20, HSIZE_WORD, 32'h0, 4'h0);
    run_beats();
    check("t5_low", 32'(lowcnt), 32'd3);
    check("t5_cycles", 32'(cyc), 32'd5);
    check("t5_rdata", got_at(0), 32'h13572468);

    // Five wait states, window at 0x1000: edges of the window.
    sel = 2'd2;
    clear_stats();
    add(1, 32'h1008, HSIZE_WORD, 32'h12345678, 4'hF);
    add(1, 32'h10FC, HSIZE_WORD, 32'h0BADF00D, 4'hF);
    add(0, 32'h0FFC, HSIZE_WORD, 32'h0, 4'h0);
    add(0, 32'h1100, HSIZE_WORD, 32'h0, 4'h0);
    add(0, 32'h10FC, HSIZE_WORD, 32'h0, 4'h0);
    run_beats();
    check("t6_errcyc", 32'(errcnt), 32'd4);
    check("t6_top_word", got_at(0), 32'h0BADF00D);

    // Reset during the second wait cycle of a write aborts it.
    clear_stats();
    b_hsel = 1'b1; b_htrans = 2'b10; b_hwrite = 1'b1; b_haddr = 32'h1008; b_hsize = HSIZE_WORD;
    @(posedge clk); #1;
    b_hsel = 1'b0; b_htrans = 2'b00; b_hwdata = 32'hCAFEF00D; b_hwstrb = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_rst_hready", 32'(d_rdy), 32'd1);
    check("t7_rst_hresp", 32'(d_resp), 32'd0);
    check("t7_low", 32'(lowcnt), 32'd2);
    @(posedge clk); #1;
    bus_idle();
    clear_stats();
    add(0, 32'h1008, HSIZE_WORD, 32'h0, 4'h0);
    run_beats();
    check("t7_unchanged", got_at(0), 32'h12345678);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
